// File: rtl/ifsram_row_sched.sv
// Row scheduler for the ifmap SRAM read path: sequences row loads into the
// 4-slot ring and one ring-phase read per output row of a 3x3 same conv.
module ifsram_row_sched #(
    parameter int ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sched_start,
    input  logic [ROW_BITS-1:0] cfg_row_total,
    output logic                sched_busy,
    output logic                sched_done,
    output logic                sched_err,
    output logic                ld_start,
    output logic [ROW_BITS-1:0] ld_row,
    output logic [1:0]          ld_slot,
    input  logic                ld_done,
    output logic                if_read_start,
    output logic [2:0]          current_state,
    input  logic                if_read_done,
    output logic [ROW_BITS-1:0] out_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_LDW,
        S_RD,
        S_RDW,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [ROW_BITS-1:0] h_q, h_n;
    logic [ROW_BITS-1:0] row_n, ldr_n;
    logic                err_q, err_n;
    logic [2:0]          cs_n;
    // One extra bit so H = 2^ROW_BITS-1 cannot wrap the comparisons
    logic [ROW_BITS:0]   r_p1, r_p2;
    logic                last_row;

    assign r_p1     = {1'b0, out_row} + 1'b1;
    assign r_p2     = {1'b0, out_row} + 2'd2;
    assign last_row = (r_p1 == {1'b0, h_q});
    assign ld_slot  = ld_row[1:0];

    function automatic logic [2:0] phase(
        input logic [ROW_BITS-1:0] r,
        input logic [ROW_BITS-1:0] h
    );
        logic [ROW_BITS-1:0] rm;
        rm = r - 1'b1;
        if (r == '0)
            return 3'd1;
        else if (({1'b0, r} + 1'b1) == {1'b0, h})
            return 3'd6;
        else
            return 3'd2 + {1'b0, rm[1:0]};
    endfunction

    always_comb begin
        state_n = state;
        h_n     = h_q;
        row_n   = out_row;
        ldr_n   = ld_row;
        err_n   = err_q;
        cs_n    = current_state;
        unique case (state)
            S_IDLE: begin
                cs_n = 3'd0;
                if (sched_start) begin
                    h_n   = cfg_row_total;
                    row_n = '0;
                    ldr_n = '0;
                    if (cfg_row_total < ROW_BITS'(2)) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        err_n   = 1'b0;
                        state_n = S_LD;
                    end
                end
            end
            S_LD: state_n = S_LDW;
            S_LDW: begin
                if (ld_done) begin
                    if (ld_row == '0) begin
                        ldr_n   = ROW_BITS'(1);
                        state_n = S_LD;
                    end else begin
                        cs_n    = phase(out_row, h_q);
                        state_n = S_RD;
                    end
                end
            end
            S_RD: state_n = S_RDW;
            S_RDW: begin
                if (if_read_done) begin
                    if (last_row) begin
                        cs_n    = 3'd0;
                        state_n = S_DONE;
                    end else if (r_p2 < {1'b0, h_q}) begin
                        row_n   = r_p1[ROW_BITS-1:0];
                        ldr_n   = r_p2[ROW_BITS-1:0];
                        state_n = S_LD;
                    end else begin
                        row_n   = r_p1[ROW_BITS-1:0];
                        cs_n    = phase(r_p1[ROW_BITS-1:0], h_q);
                        state_n = S_RD;
                    end
                end
            end
            S_DONE: begin
                cs_n    = 3'd0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            h_q           <= '0;
            err_q         <= 1'b0;
            out_row       <= '0;
            ld_row        <= '0;
            current_state <= 3'd0;
            ld_start      <= 1'b0;
            if_read_start <= 1'b0;
            sched_busy    <= 1'b0;
            sched_done    <= 1'b0;
            sched_err     <= 1'b0;
        end else begin
            state         <= state_n;
            h_q           <= h_n;
            err_q         <= err_n;
            out_row       <= row_n;
            ld_row        <= ldr_n;
            current_state <= cs_n;
            ld_start      <= (state_n == S_LD);
            if_read_start <= (state_n == S_RD);
            sched_busy    <= (state_n inside {S_LD, S_LDW, S_RD, S_RDW});
            sched_done    <= (state_n == S_DONE);
            sched_err     <= (state_n == S_DONE) && err_n;
        end
    end

endmodule

// File: tb/tb_ifsram_row_sched.sv
// Directed bench for ifsram_row_sched: the initial block plays both
// responders and logs load/read/done events for comparison.
module tb_ifsram_row_sched;

    localparam int RB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          sched_start;
    logic [RB-1:0] cfg_row_total;
    logic          sched_busy;
    logic          sched_done;
    logic          sched_err;
    logic          ld_start;
    logic [RB-1:0] ld_row;
    logic [1:0]    ld_slot;
    logic          ld_done;
    logic          if_read_start;
    logic [2:0]    current_state;
    logic          if_read_done;
    logic [RB-1:0] out_row;

    ifsram_row_sched #(.ROW_BITS(RB)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_start  (sched_start),
        .cfg_row_total(cfg_row_total),
        .sched_busy   (sched_busy),
        .sched_done   (sched_done),
        .sched_err    (sched_err),
        .ld_start     (ld_start),
        .ld_row       (ld_row),
        .ld_slot      (ld_slot),
        .ld_done      (ld_done),
        .if_read_start(if_read_start),
        .current_state(current_state),
        .if_read_done (if_read_done),
        .out_row      (out_row)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int evlog[$];
    int tlog[$];
    int busy_bad;
    int cs_bad;
    int post_rst_done;
    bit fin;

    function automatic logic [31:0] outs();
        return {6'd0, sched_busy, sched_done, sched_err, ld_start,
                ld_row, ld_slot, if_read_start, current_state, out_row};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int e[$], input int got[$]);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], e[i]);
    endtask

    function automatic int first_t();
        return (tlog.size() > 0) ? tlog[0] : -1;
    endfunction

    // Event codes: load 1000+row*10+slot, read 2000+row*10+phase,
    // done 9000 (+100 with err). tlog holds the cycle since start.
    task automatic run(input int h, input int lat_ld, input int lat_rd,
                       input bit strays, input int rst_at, input int budget);
        int ld_t, rd_t, cyc, nrd;
        logic [2:0] cs_hold;
        evlog.delete();
        tlog.delete();
        busy_bad = 0;
        cs_bad   = 0;
        fin      = 0;
        ld_t = 0; rd_t = 0; cyc = 0; nrd = 0;
        cs_hold = 3'd0;
        @(negedge clk);
        ld_done       = 1'b0;
        if_read_done  = 1'b0;
        sched_start   = 1'b1;
        cfg_row_total = RB'(h);
        @(negedge clk);
        if (strays) cfg_row_total = RB'(2);
        while (!fin && cyc < budget) begin
            cyc++;
            sched_start  = 1'b0;
            ld_done      = 1'b0;
            if_read_done = 1'b0;
            if (ld_t > 0) begin
                ld_t--;
                if (ld_t == 0) ld_done = 1'b1;
            end
            if (rd_t > 0) begin
                rd_t--;
                if (rd_t == 0) if_read_done = 1'b1;
            end
            if (strays && rd_t == 25) begin
                sched_start = 1'b1;
                ld_done     = 1'b1;
            end
            if (strays && ld_t == 2) if_read_done = 1'b1;
            if (sched_done) begin
                evlog.push_back(9000 + (sched_err ? 100 : 0));
                tlog.push_back(cyc);
                if (sched_busy) busy_bad++;
                fin = 1;
            end else if (!sched_busy) begin
                busy_bad++;
            end
            if (ld_start) begin
                evlog.push_back(1000 + int'(ld_row) * 10 + int'(ld_slot));
                tlog.push_back(cyc);
                ld_t = lat_ld;
            end
            if (if_read_start) begin
                evlog.push_back(2000 + int'(out_row) * 10 + int'(current_state));
                tlog.push_back(cyc);
                rd_t    = lat_rd;
                cs_hold = current_state;
                nrd++;
                if (rst_at != 0 && nrd == rst_at) begin
                    reset        = 1'b0;
                    ld_done      = 1'b0;
                    if_read_done = 1'b0;
                    @(negedge clk);
                    chk("rst_mid_outputs", outs(), 32'd0);
                    reset = 1'b1;
                    post_rst_done = 0;
                    repeat (4) begin
                        @(negedge clk);
                        if (sched_done) post_rst_done++;
                    end
                    fin = 1;
                end
            end else if (rd_t > 0 && current_state !== cs_hold) begin
                cs_bad++;
            end
            if (!fin) @(negedge clk);
        end
        ld_done      = 1'b0;
        if_read_done = 1'b0;
        sched_start  = 1'b0;
    endtask

    initial begin
        int e[$];
        reset         = 1'b0;
        sched_start   = 1'b0;
        ld_done       = 1'b0;
        if_read_done  = 1'b0;
        cfg_row_total = '0;
        post_rst_done = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b1;

        run(6, 3, 3, 0, 0, 2000);
        chk("h6_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 1033, 2023,
              1040, 2034, 1051, 2045, 2056, 9000};
        chk_seq("h6", e, evlog);
        chk("h6_first_ld_cyc", first_t(), 1);
        chk("h6_busy", busy_bad, 0);

        run(7, 2, 2, 0, 0, 2000);
        chk("h7_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 1033, 2023, 1040,
              2034, 1051, 2045, 1062, 2052, 2066, 9000};
        chk_seq("h7", e, evlog);

        run(2, 3, 3, 0, 0, 2000);
        chk("h2_fin", fin, 1);
        e = '{1000, 1011, 2001, 2016, 9000};
        chk_seq("h2", e, evlog);

        run(1, 3, 3, 0, 0, 100);
        chk("h1_fin", fin, 1);
        e = '{9100};
        chk_seq("h1", e, evlog);
        chk("h1_done_cyc", first_t(), 1);

        run(0, 3, 3, 0, 0, 100);
        chk("h0_fin", fin, 1);
        e = '{9100};
        chk_seq("h0", e, evlog);
        chk("h0_done_cyc", first_t(), 1);

        run(5, 3, 50, 1, 0, 3000);
        chk("stray_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 1033, 2023,
              1040, 2034, 2046, 9000};
        chk_seq("stray", e, evlog);
        chk("stray_cs_stable", cs_bad, 0);
        chk("stray_busy", busy_bad, 0);

        run(6, 3, 3, 0, 3, 2000);
        chk("rst_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 1033, 2023};
        chk_seq("rst", e, evlog);
        chk("rst_no_done", post_rst_done, 0);

        run(3, 2, 2, 0, 0, 2000);
        chk("h3_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 2026, 9000};
        chk_seq("h3", e, evlog);

        run(4, 1, 1, 0, 0, 2000);
        chk("zl_fin", fin, 1);
        e = '{1000, 1011, 2001, 1022, 2012, 1033, 2023, 2036, 9000};
        chk_seq("zl", e, evlog);
        e = '{1, 3, 5, 7, 9, 11, 13, 15, 17};
        chk_seq("zl_cyc", e, tlog);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
